// File: rtl/perceptron_pkg.sv
// Shared widths, FSM state type and digit-class prototype table for the feature encoder.
// Table entries are packed with class 0 in the least significant slot.
package perceptron_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int EDGE_W      = 3;
  localparam int CURVE_W     = 4;
  localparam int CLASS_W     = 4;
  localparam int CNT_W       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Index k holds the feature for digit class k (listed here class 9 down to 0).
  localparam logic [NUM_CLASSES-1:0][EDGE_W-1:0] PROTO_EDGES = {
    3'd1, 3'd0, 3'd3, 3'd1, 3'd3, 3'd4, 3'd0, 3'd2, 3'd2, 3'd0
  };
  localparam logic [NUM_CLASSES-1:0][CURVE_W-1:0] PROTO_CURVES = {
    4'd4, 4'd8, 4'd0, 4'd3, 4'd2, 4'd0, 4'd6, 4'd2, 4'd0, 4'd4
  };
endpackage

// File: rtl/perceptron_proto_rom.sv
// Combinational digit-class to {edges, curves} prototype lookup; zero features for illegal classes.
// No state, no latency, no flow control.
module perceptron_proto_rom
  import perceptron_pkg::*;
(
  input  logic [CLASS_W-1:0] i_class,
  output logic [EDGE_W-1:0]  o_edges,
  output logic [CURVE_W-1:0] o_curves,
  output logic               o_legal
);

  logic w_legal;

  always_comb begin
    w_legal  = (i_class < CLASS_W'(NUM_CLASSES));
    o_edges  = '0;
    o_curves = '0;
    if (w_legal) begin
      o_edges  = PROTO_EDGES[i_class];
      o_curves = PROTO_CURVES[i_class];
    end
    o_legal = w_legal;
  end

endmodule

// File: rtl/perceptron_feature_encoder.sv
// Turns an accepted digit-class request into REPEAT identical feature frames, first frame one cycle after acceptance.
// Frames hold stable under feat_ready backpressure; requests are refused (req_ready low) until the last frame is taken.
module perceptron_feature_encoder
  import perceptron_pkg::*;
#(
  parameter int REPEAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [CLASS_W-1:0] req_class,
  output logic               req_ready,
  output logic               feat_valid,
  output logic [EDGE_W-1:0]  feat_edges,
  output logic [CURVE_W-1:0] feat_curves,
  output logic               feat_last,
  input  logic               feat_ready,
  output logic               err,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(REPEAT);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CLASS_W-1:0]   r_class;
  logic [EDGE_W-1:0]    r_edges;
  logic [CURVE_W-1:0]   r_curves;
  logic                 r_err;

  logic [CLASS_W-1:0]   w_rom_class;
  logic [EDGE_W-1:0]    w_rom_edges;
  logic [CURVE_W-1:0]   w_rom_curves;
  logic                 w_rom_legal;
  logic                 w_req_fire;
  logic                 w_feat_fire;
  logic                 w_last;

  // Outside IDLE the ROM sees the latched class, so new req_class values cannot leak in.
  assign w_rom_class = (r_state == ST_IDLE) ? req_class : r_class;

  perceptron_proto_rom u_rom (
    .i_class  (w_rom_class),
    .o_edges  (w_rom_edges),
    .o_curves (w_rom_curves),
    .o_legal  (w_rom_legal)
  );

  assign req_ready   = (r_state == ST_IDLE);
  assign feat_valid  = (r_state == ST_EMIT);
  assign w_last      = feat_valid && (r_cnt == ONE_CNT);
  assign w_req_fire  = req_valid && req_ready;
  assign w_feat_fire = feat_valid && feat_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_class  <= '0;
      r_edges  <= '0;
      r_curves <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            if (w_rom_legal) begin
              r_state  <= ST_EMIT;
              r_class  <= req_class;
              r_cnt    <= LOAD_CNT;
              r_edges  <= w_rom_edges;
              r_curves <= w_rom_curves;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (w_feat_fire) begin
            // Counter stops at 1; the final handshake clears features so they read 0 in IDLE.
            if (w_last) begin
              r_state  <= ST_IDLE;
              r_cnt    <= '0;
              r_edges  <= '0;
              r_curves <= '0;
            end else begin
              r_cnt <= r_cnt - ONE_CNT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign feat_edges  = r_edges;
  assign feat_curves = r_curves;
  assign feat_last   = w_last;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);

endmodule
